// File: rtl/seven_seg_capture_pkg.sv
// Shared definitions for the 7-segment capture observer and its glyph decoder.
package seven_seg_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    // Active-high gfedcba patterns, bit 0 = segment a.
    localparam logic [6:0] SEG_GLYPH_0 = 7'h3F;
    localparam logic [6:0] SEG_GLYPH_1 = 7'h06;
    localparam logic [6:0] SEG_GLYPH_2 = 7'h5B;
    localparam logic [6:0] SEG_GLYPH_3 = 7'h4F;
    localparam logic [6:0] SEG_GLYPH_4 = 7'h66;
    localparam logic [6:0] SEG_GLYPH_5 = 7'h6D;
    localparam logic [6:0] SEG_GLYPH_6 = 7'h7D;
    localparam logic [6:0] SEG_GLYPH_7 = 7'h07;
    localparam logic [6:0] SEG_GLYPH_8 = 7'h7F;
    localparam logic [6:0] SEG_GLYPH_9 = 7'h6F;
    localparam logic [6:0] SEG_GLYPH_A = 7'h77;
    localparam logic [6:0] SEG_GLYPH_B = 7'h7C;
    localparam logic [6:0] SEG_GLYPH_C = 7'h39;
    localparam logic [6:0] SEG_GLYPH_D = 7'h5E;
    localparam logic [6:0] SEG_GLYPH_E = 7'h79;
    localparam logic [6:0] SEG_GLYPH_F = 7'h71;

    // Level of one anode line when its digit is dark; a blank bus is all of these.
    localparam logic AN_OFF = 1'b1;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Maps an active-high gfedcba segment pattern to its hex nibble; anything
// outside the 16 glyphs decodes to 0 and flags invalid.
module seg7_glyph_decode
    import seven_seg_capture_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       invalid
);

    always_comb begin
        nibble  = 4'h0;
        invalid = 1'b0;
        case (pattern)
            SEG_GLYPH_0: nibble = 4'h0;
            SEG_GLYPH_1: nibble = 4'h1;
            SEG_GLYPH_2: nibble = 4'h2;
            SEG_GLYPH_3: nibble = 4'h3;
            SEG_GLYPH_4: nibble = 4'h4;
            SEG_GLYPH_5: nibble = 4'h5;
            SEG_GLYPH_6: nibble = 4'h6;
            SEG_GLYPH_7: nibble = 4'h7;
            SEG_GLYPH_8: nibble = 4'h8;
            SEG_GLYPH_9: nibble = 4'h9;
            SEG_GLYPH_A: nibble = 4'hA;
            SEG_GLYPH_B: nibble = 4'hB;
            SEG_GLYPH_C: nibble = 4'hC;
            SEG_GLYPH_D: nibble = 4'hD;
            SEG_GLYPH_E: nibble = 4'hE;
            SEG_GLYPH_F: nibble = 4'hF;
            default:     invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Observer for a multiplexed 7-segment display: resynchronizes the anode and
// segment lines and rebuilds the displayed hex value digit by digit.
module seven_seg_capture
    import seven_seg_capture_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 33554432
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_DIGITS-1:0]   an,
    input  logic [6:0]            seg,
    output logic                  busy,
    output logic                  done,
    output logic [4*N_DIGITS-1:0] value,
    output logic [N_DIGITS-1:0]   digit_valid,
    output logic [N_DIGITS-1:0]   glyph_err,
    output logic                  an_err,
    output logic                  timeout
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0]       STABLE_MAX  = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0]       STABLE_PRE  = SW'(STABLE_CYCLES - 2);
    localparam logic [TW-1:0]       TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [N_DIGITS-1:0] AN_BLANK    = {N_DIGITS{AN_OFF}};

    state_t                  state, state_nxt;
    logic [N_DIGITS-1:0]     an_m, an_s;
    logic [6:0]              seg_m, seg_s;
    logic [N_DIGITS+6:0]     prev_s;
    logic [SW-1:0]           stab_cnt;
    logic [TW-1:0]           to_cnt;
    logic                    same, accept, blank, single, clr;
    logic [3:0]              nibble;
    logic                    bad_glyph;
    logic [4*N_DIGITS-1:0]   value_nxt;
    logic [N_DIGITS-1:0]     valid_nxt, gerr_nxt;
    logic                    an_err_nxt, timeout_nxt;

    seg7_glyph_decode u_decode (
        .pattern (~seg_s),
        .nibble  (nibble),
        .invalid (bad_glyph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_m   <= AN_BLANK;
            an_s   <= AN_BLANK;
            seg_m  <= '1;
            seg_s  <= '1;
            prev_s <= {AN_BLANK, 7'h7F};
        end else begin
            an_m   <= an;
            an_s   <= an_m;
            seg_m  <= seg;
            seg_s  <= seg_m;
            prev_s <= {an_s, seg_s};
        end
    end

    // One acceptance event per stable window: the cycle the count reaches its cap.
    assign same   = ({an_s, seg_s} == prev_s);
    assign accept = same && (stab_cnt == STABLE_PRE);
    assign blank  = (an_s == AN_BLANK);
    assign single = ($countones(~an_s) == 1);
    assign busy   = (state == ST_CAPTURE);
    assign done   = (state == ST_DONE);

    always_comb begin
        state_nxt   = state;
        value_nxt   = value;
        valid_nxt   = digit_valid;
        gerr_nxt    = glyph_err;
        an_err_nxt  = an_err;
        timeout_nxt = timeout;
        clr         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    value_nxt   = '0;
                    valid_nxt   = '0;
                    gerr_nxt    = '0;
                    an_err_nxt  = 1'b0;
                    timeout_nxt = 1'b0;
                    clr         = 1'b1;
                    state_nxt   = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (accept && !blank) begin
                    if (single) begin
                        for (int i = 0; i < N_DIGITS; i++) begin
                            if (!an_s[i]) begin
                                value_nxt[4*i +: 4] = nibble;
                                valid_nxt[i]        = 1'b1;
                                gerr_nxt[i]         = bad_glyph;
                            end
                        end
                    end else begin
                        an_err_nxt = 1'b1;
                    end
                end
                // Full coverage takes priority over a coincident timeout.
                if (&valid_nxt) begin
                    state_nxt = ST_DONE;
                end else if (to_cnt == TIMEOUT_MAX) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            stab_cnt    <= '0;
            to_cnt      <= '0;
            value       <= '0;
            digit_valid <= '0;
            glyph_err   <= '0;
            an_err      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            value       <= value_nxt;
            digit_valid <= valid_nxt;
            glyph_err   <= gerr_nxt;
            an_err      <= an_err_nxt;
            timeout     <= timeout_nxt;
            if (clr || !same)
                stab_cnt <= '0;
            else if (stab_cnt != STABLE_MAX)
                stab_cnt <= stab_cnt + SW'(1);
            if (clr)
                to_cnt <= '0;
            else if (state == ST_CAPTURE)
                to_cnt <= to_cnt + TW'(1);
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench: drives display hold sequences and checks the captured result
// against a per-hold reference model on every done pulse.
module tb_seven_seg_capture;

    localparam int ND = 8;
    localparam int ST = 16;
    localparam int TO = 1000;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        busy, done, an_err, timeout;
    logic [31:0] value;
    logic [7:0]  digit_valid, glyph_err;

    seven_seg_capture #(.N_DIGITS(ND), .STABLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .an(an), .seg(seg),
        .busy(busy), .done(done), .value(value), .digit_valid(digit_valid),
        .glyph_err(glyph_err), .an_err(an_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic [7:0]  dv;
        logic [7:0]  ge;
        logic        ae;
        logic        to;
        int          lat;
    } exp_t;

    typedef struct {
        logic [7:0] an;
        logic [6:0] pat;
        int         len;
    } hold_t;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int    checks = 0, failures = 0;
    int    cyc = 0, start_cyc = 0;
    int    done_count = 0, exp_dones = 0;
    exp_t  expq[$];
    hold_t seq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a hold shown for at least ST cycles is accepted once, in order,
    // until all digits are covered; incomplete coverage means a timeout.
    function automatic exp_t model(hold_t s[$]);
        exp_t  e;
        hold_t m[$];
        e = '{default: 0};
        e.lat = -1;
        foreach (s[k]) begin
            if (m.size() > 0 && m[m.size()-1].an == s[k].an && m[m.size()-1].pat == s[k].pat)
                m[m.size()-1].len += s[k].len;
            else
                m.push_back(s[k]);
        end
        foreach (m[k]) begin
            int   idx;
            logic found;
            logic [3:0] nib;
            if (&e.dv) break;
            if (m[k].len < ST || m[k].an == 8'hFF) continue;
            if ($countones(~m[k].an) != 1) begin
                e.ae = 1'b1;
                continue;
            end
            idx = 0;
            for (int i = 0; i < ND; i++) if (!m[k].an[i]) idx = i;
            found = 1'b0;
            nib = 4'h0;
            for (int g = 0; g < 16; g++) if (glyph[g] == m[k].pat) begin nib = g[3:0]; found = 1'b1; end
            e.value[4*idx +: 4] = nib;
            e.dv[idx] = 1'b1;
            e.ge[idx] = !found;
        end
        if (!(&e.dv)) e.to = 1'b1;
        return e;
    endfunction

    task automatic add_hold(logic [7:0] a, logic [6:0] p, int l);
        hold_t h;
        h.an = a; h.pat = p; h.len = l;
        seq.push_back(h);
    endtask

    task automatic add_scan(logic [31:0] v, int len, bit glitch, int ndig);
        for (int i = 0; i < ndig; i++) begin
            logic [7:0] a = 8'hFF;
            a[i] = 1'b0;
            add_hold(a, glyph[v[4*i +: 4]], len);
            if (glitch) add_hold(8'hFF, 7'h7F, 2);
        end
    endtask

    task automatic begin_capture(bit push, exp_t e);
        if (push) begin expq.push_back(e); exp_dones++; end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        start_cyc = cyc;
        chk("busy_in_capture", {31'd0, busy}, 32'd1);
    endtask

    task automatic drive(hold_t s[$], bit poke);
        foreach (s[k]) begin
            an  = s[k].an;
            seg = ~s[k].pat;
            if (poke && k == 4) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            repeat (s[k].len - 1) begin @(posedge clk); #1; end
        end
        an = '1; seg = '1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (expq.size() != 0 && n < 3000) begin @(posedge clk); n++; end
        #1;
        if (expq.size() != 0) begin
            checks++; failures++;
            $display("FAIL done_wait: no done within %0d cycles, pending=%0d", n, expq.size());
            expq.delete();
        end
        repeat (20) begin @(posedge clk); #1; end
    endtask

    task automatic run(hold_t s[$], bit poke, int lat);
        exp_t e = model(s);
        e.lat = lat;
        begin_capture(1'b1, e);
        drive(s, poke);
        wait_done();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            done_count++;
            if (expq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done: done=1 with no capture pending at cycle %0d", cyc);
            end else begin
                e = expq.pop_front();
                chk("value", value, e.value);
                chk("digit_valid", {24'd0, digit_valid}, {24'd0, e.dv});
                chk("glyph_err", {24'd0, glyph_err}, {24'd0, e.ge});
                chk("an_err", {31'd0, an_err}, {31'd0, e.ae});
                chk("timeout", {31'd0, timeout}, {31'd0, e.to});
                chk("busy_at_done", {31'd0, busy}, 32'd0);
                if (e.lat >= 0) chk("timeout_latency", cyc - start_cyc, e.lat);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        hold_t s1[$], s2[$];
        exp_t  e;
        rst = 1'b1; start = 1'b0; an = '1; seg = '1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_value", value, 32'd0);
        chk("rst_digit_valid", {24'd0, digit_valid}, 32'd0);
        chk("rst_glyph_err", {24'd0, glyph_err}, 32'd0);
        chk("rst_an_err", {31'd0, an_err}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        #11 rst = 1'b0;
        repeat (5) begin @(posedge clk); #1; end

        // Plain scan, with a start pulse mid-capture that must be ignored.
        seq.delete(); add_scan(32'h12345678, 32, 1'b0, 8);
        run(seq, 1'b1, -1);

        // Short holds separated by glitches, then a proper scan.
        seq.delete(); add_scan(32'h0BADF00D, 10, 1'b1, 8); s1 = seq;
        seq.delete(); add_scan(32'hDEADBEEF, 20, 1'b0, 8); s2 = seq;
        e = model({s1, s2});
        begin_capture(1'b1, e);
        drive(s1, 1'b0);
        chk("short_holds_digit_valid", {24'd0, digit_valid}, {24'd0, model(s1).dv});
        drive(s2, 1'b0);
        wait_done();

        // Non-glyph pattern on digit 3.
        seq.delete();
        for (int i = 0; i < ND; i++) begin
            logic [7:0] a = 8'hFF;
            a[i] = 1'b0;
            add_hold(a, (i == 3) ? 7'h49 : glyph[0], 32);
        end
        run(seq, 1'b0, -1);

        // Two anodes low, then a normal scan.
        seq.delete(); add_hold(8'hF3, glyph[5], 40); add_scan(32'hCAFEF00D, 32, 1'b1, 8);
        run(seq, 1'b0, -1);

        // Digit 7 never shown: capture must time out.
        seq.delete();
        for (int r = 0; r < 5; r++) add_scan(32'h01234567, 32, 1'b1, 7);
        run(seq, 1'b0, TO);

        // Reset mid-capture after four digits, then a fresh capture.
        seq.delete(); add_scan(32'h00004321, 32, 1'b1, 4);
        e = model(seq);
        begin_capture(1'b0, e);
        drive(seq, 1'b0);
        chk("pre_reset_digit_valid", {24'd0, digit_valid}, {24'd0, e.dv});
        rst = 1'b1;
        #2;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_value", value, 32'd0);
        chk("abort_digit_valid", {24'd0, digit_valid}, 32'd0);
        #4 rst = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        seq.delete(); add_scan(32'h89ABCDEF, 24, 1'b0, 8);
        run(seq, 1'b0, -1);

        // Randomized prefixes of mixed holds, closed by a full scan.
        for (int t = 0; t < 6; t++) begin
            seq.delete();
            for (int h = 0; h < 6; h++) begin
                logic [7:0] a = 8'hFF;
                logic [6:0] p;
                int x = $urandom_range(0, 9);
                int b1 = $urandom_range(0, 7);
                if (x == 1) begin
                    a[b1] = 1'b0;
                    a[(b1 + 1 + $urandom_range(0, 6)) % 8] = 1'b0;
                end else if (x != 0) begin
                    a[b1] = 1'b0;
                end
                p = ($urandom_range(0, 9) < 7) ? glyph[$urandom_range(0, 15)] : 7'($urandom_range(0, 127));
                add_hold(a, p, $urandom_range(5, 40));
                add_hold(8'hFF, 7'h7F, 2);
            end
            add_scan($urandom, 20, 1'b0, 8);
            run(seq, 1'b0, -1);
        end

        chk("done_pulse_count", done_count, exp_dones);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
